// File: rtl/pipe_pkg.sv
// Shared encodings for the writeback stage: source selects, load types and FSM states.
package pipe_pkg;

    localparam int PIPE_XLEN    = 32;
    localparam int PIPE_RADDR_W = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WRITE    = 2'b01,
        ST_WAIT_MEM = 2'b10
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/halfword/word from a
// little-endian read word and sign- or zero-extends it; flags misaligned or illegal loads.
module load_align
    import pipe_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      load_type_i,
    input  logic [1:0]      addr_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);

    logic [15:0] half;
    logic [7:0]  byteVal;

    always_comb begin
        half    = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byteVal = rdata_i[8*addr_i +: 8];
        data_o  = '0;
        err_o   = 1'b0;
        unique case (load_type_i)
            LD_LW: begin
                if (addr_i != 2'b00) err_o = 1'b1;
                else                 data_o = rdata_i;
            end
            LD_LH, LD_LHU: begin
                if (addr_i[0]) begin
                    err_o = 1'b1;
                end else if (load_type_i == LD_LH) begin
                    data_o = {{(XLEN-16){half[15]}}, half};
                end else begin
                    data_o = {{(XLEN-16){1'b0}}, half};
                end
            end
            LD_LB:   data_o = {{(XLEN-8){byteVal[7]}}, byteVal};
            LD_LBU:  data_o = {{(XLEN-8){1'b0}}, byteVal};
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction at a time, waits for load data when needed,
// and presents a single-cycle register-file write plus a forwarding tap and retire counter.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = PIPE_XLEN,
    parameter int RADDR_W = PIPE_RADDR_W,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rwd,
    input  logic [1:0]         in_wb_sel,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_link_addr,
    input  logic [2:0]         in_load_type,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic [RADDR_W-1:0] rwd,
    output logic [XLEN-1:0]    wb_data,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rwd,
    output logic [XLEN-1:0]    fwd_data,
    output logic               align_err,
    output logic               busy,
    output logic [CNT_W-1:0]   retire_count
);

    wb_state_e          state_q, state_d;
    logic [RADDR_W-1:0] rwd_q, rwd_d;
    logic [XLEN-1:0]    wbData_q, wbData_d;
    logic               fwdValid_q;
    logic               alignErr_q, alignErr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RADDR_W-1:0] ldRwd_q, ldRwd_d;
    logic [2:0]         ldType_q, ldType_d;
    logic [1:0]         ldAddr_q, ldAddr_d;

    logic               accept;
    logic               retire;
    logic [XLEN-1:0]    alignData;
    logic               alignErr;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i     (mem_rdata),
        .load_type_i (ldType_q),
        .addr_i      (ldAddr_q),
        .data_o      (alignData),
        .err_o       (alignErr)
    );

    assign in_ready = (state_q != ST_WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // Every retirement is counted on the edge where its outcome is decided.
    always_comb begin
        state_d    = ST_IDLE;
        rwd_d      = '0;
        wbData_d   = wbData_q;
        alignErr_d = 1'b0;
        retire     = 1'b0;
        ldRwd_d    = ldRwd_q;
        ldType_d   = ldType_q;
        ldAddr_d   = ldAddr_q;

        if (state_q == ST_WAIT_MEM) begin
            state_d = ST_WAIT_MEM;
            if (mem_rvalid) begin
                retire  = 1'b1;
                state_d = ST_IDLE;
                if (alignErr) begin
                    alignErr_d = 1'b1;
                end else if (ldRwd_q != '0) begin
                    rwd_d    = ldRwd_q;
                    wbData_d = alignData;
                    state_d  = ST_WRITE;
                end
            end
        end else if (accept) begin
            unique case (in_wb_sel)
                WB_SEL_ALU, WB_SEL_LINK: begin
                    retire = 1'b1;
                    if (in_rwd != '0) begin
                        rwd_d    = in_rwd;
                        wbData_d = (in_wb_sel == WB_SEL_ALU) ? in_alu_result : in_link_addr;
                        state_d  = ST_WRITE;
                    end
                end
                WB_SEL_LOAD: begin
                    ldRwd_d  = in_rwd;
                    ldType_d = in_load_type;
                    ldAddr_d = in_alu_result[1:0];
                    state_d  = ST_WAIT_MEM;
                end
                default: retire = 1'b1;
            endcase
        end

        count_d = count_q + (retire ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rwd_q      <= '0;
            wbData_q   <= '0;
            fwdValid_q <= 1'b0;
            alignErr_q <= 1'b0;
            count_q    <= '0;
            ldRwd_q    <= '0;
            ldType_q   <= '0;
            ldAddr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rwd_q      <= rwd_d;
            wbData_q   <= wbData_d;
            fwdValid_q <= (rwd_d != '0);
            alignErr_q <= alignErr_d;
            count_q    <= count_d;
            ldRwd_q    <= ldRwd_d;
            ldType_q   <= ldType_d;
            ldAddr_q   <= ldAddr_d;
        end
    end

    assign rwd          = rwd_q;
    assign wb_data      = wbData_q;
    assign fwd_valid    = fwdValid_q;
    assign fwd_rwd      = rwd_q;
    assign fwd_data     = wbData_q;
    assign align_err    = alignErr_q;
    assign busy         = (state_q != ST_IDLE);
    assign retire_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, reset-mid-load sequence,
// and randomized traffic compared against a transaction-level reference model.
module tb_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rwd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_link_addr;
    logic [2:0]  in_load_type;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rwd;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rwd;
    logic [31:0] fwd_data;
    logic        align_err;
    logic        busy;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    bit          mPending;
    logic [4:0]  mRwd;
    logic [2:0]  mType;
    logic [1:0]  mAddr;
    logic [31:0] mCount;
    logic [31:0] expData;
    logic [4:0]  expRwd;
    bit          expErr;

    typedef struct {
        bit          valid;
        logic [4:0]  rwdIn;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] link;
        logic [2:0]  lt;
        bit          rvalid;
        logic [31:0] rdata;
        logic [4:0]  expRwd;
        logic [31:0] expData;
        bit          expErr;
        bit          expReady;
        int          expCount;
    } vec_t;

    vec_t vecs[$];

    wb_stage dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rwd        (in_rwd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_link_addr  (in_link_addr),
        .in_load_type  (in_load_type),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rwd           (rwd),
        .wb_data       (wb_data),
        .fwd_valid     (fwd_valid),
        .fwd_rwd       (fwd_rwd),
        .fwd_data      (fwd_data),
        .align_err     (align_err),
        .busy          (busy),
        .retire_count  (retire_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Loads are modelled by shifting the word down to the addressed byte and
    // truncating/extending with plain arithmetic.
    function automatic void modelLoad(input logic [31:0] word, input logic [2:0] t,
                                      input logic [1:0] a, output logic [31:0] d, output bit err);
        logic [31:0] shifted;
        logic [15:0] h;
        logic [7:0]  b;
        shifted = word >> (8 * int'(a));
        h = shifted[15:0];
        b = shifted[7:0];
        d = 32'h0;
        err = 1'b0;
        case (t)
            3'd0: if (a != 2'd0) err = 1'b1; else d = word;
            3'd1: if (a[0]) err = 1'b1; else d = 32'($signed(h));
            3'd2: if (a[0]) err = 1'b1; else d = 32'(h);
            3'd3: d = 32'($signed(b));
            3'd4: d = 32'(b);
            default: err = 1'b1;
        endcase
    endfunction

    task automatic modelStep();
        logic [31:0] d;
        bit e;
        expRwd = 5'd0;
        expErr = 1'b0;
        if (RST) begin
            mPending = 1'b0;
            mCount   = 32'd0;
            expData  = 32'd0;
        end else if (mPending) begin
            if (mem_rvalid) begin
                modelLoad(mem_rdata, mType, mAddr, d, e);
                mPending = 1'b0;
                mCount++;
                if (e) expErr = 1'b1;
                else if (mRwd != 5'd0) begin
                    expRwd  = mRwd;
                    expData = d;
                end
            end
        end else if (in_valid) begin
            if (in_wb_sel == 2'b01) begin
                mPending = 1'b1;
                mRwd     = in_rwd;
                mType    = in_load_type;
                mAddr    = in_alu_result[1:0];
            end else begin
                mCount++;
                if (in_wb_sel != 2'b11 && in_rwd != 5'd0) begin
                    expRwd  = in_rwd;
                    expData = (in_wb_sel == 2'b00) ? in_alu_result : in_link_addr;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [4:0] r, input logic [1:0] s,
                                 input logic [31:0] alu, input logic [31:0] link,
                                 input logic [2:0] lt, input bit rv,
                                 input logic [31:0] rdata, input bit rst);
        RST           = rst;
        in_valid      = v;
        in_rwd        = r;
        in_wb_sel     = s;
        in_alu_result = alu;
        in_link_addr  = link;
        in_load_type  = lt;
        mem_rvalid    = rv;
        mem_rdata     = rdata;
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_rwd"}, 32'(rwd), 32'(expRwd));
        checkValue({tag, "_wb_data"}, wb_data, expData);
        checkValue({tag, "_fwd_valid"}, 32'(fwd_valid), 32'(expRwd != 5'd0));
        checkValue({tag, "_fwd_rwd"}, 32'(fwd_rwd), 32'(expRwd));
        checkValue({tag, "_fwd_data"}, fwd_data, expData);
        checkValue({tag, "_align_err"}, 32'(align_err), 32'(expErr));
        checkValue({tag, "_retire_count"}, retire_count, mCount);
        checkValue({tag, "_in_ready"}, 32'(in_ready), 32'(!mPending));
        checkValue({tag, "_busy"}, 32'(busy), 32'(mPending || expRwd != 5'd0));
    endtask

    function automatic void addVec(input bit v, input logic [4:0] r, input logic [1:0] s,
                                   input logic [31:0] alu, input logic [31:0] link,
                                   input logic [2:0] lt, input bit rv, input logic [31:0] rdata,
                                   input logic [4:0] eR, input logic [31:0] eD, input bit eE,
                                   input bit eRdy, input int eC);
        vec_t x;
        x.valid = v; x.rwdIn = r; x.sel = s; x.alu = alu; x.link = link; x.lt = lt;
        x.rvalid = rv; x.rdata = rdata; x.expRwd = eR; x.expData = eD; x.expErr = eE;
        x.expReady = eRdy; x.expCount = eC;
        vecs.push_back(x);
    endfunction

    initial begin
        logic [31:0] word;
        word = 32'h80FF_7F80;

        // One cycle of inputs per row, expected outputs sampled after that edge.
        addVec(1, 5, 2'b00, 32'h0000_00AB, 0, 0, 0, 0, 5, 32'h0000_00AB, 0, 1, 1);
        addVec(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_00AB, 0, 1, 1);
        addVec(1, 1, 2'b00, 32'h11, 0, 0, 0, 0, 1, 32'h11, 0, 1, 2);
        addVec(1, 2, 2'b00, 32'h22, 0, 0, 0, 0, 2, 32'h22, 0, 1, 3);
        addVec(1, 3, 2'b00, 32'h33, 0, 0, 0, 0, 3, 32'h33, 0, 1, 4);
        addVec(1, 0, 2'b00, 32'h55, 0, 0, 0, 0, 0, 32'h33, 0, 1, 5);
        addVec(1, 9, 2'b11, 32'h66, 0, 0, 0, 0, 0, 32'h33, 0, 1, 6);
        addVec(1, 6, 2'b10, 32'h77, 32'h400, 0, 0, 0, 6, 32'h400, 0, 1, 7);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 0, 32'h400, 0, 1, 7);
        addVec(1, 7, 2'b01, 32'h1000, 0, 3'd3, 0, 0, 0, 32'h400, 0, 0, 7);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 7, 32'hFFFF_FF80, 0, 1, 8);
        addVec(1, 7, 2'b01, 32'h1000, 0, 3'd4, 0, 0, 0, 32'hFFFF_FF80, 0, 0, 8);
        addVec(1, 8, 2'b00, 32'h99, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 0, 8);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 7, 32'h0000_0080, 0, 1, 9);
        addVec(1, 7, 2'b01, 32'h1002, 0, 3'd1, 0, 0, 0, 32'h0000_0080, 0, 0, 9);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 7, 32'hFFFF_80FF, 0, 1, 10);
        addVec(1, 7, 2'b01, 32'h1002, 0, 3'd2, 0, 0, 0, 32'hFFFF_80FF, 0, 0, 10);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 7, 32'h0000_80FF, 0, 1, 11);
        addVec(1, 7, 2'b01, 32'h1002, 0, 3'd0, 0, 0, 0, 32'h0000_80FF, 0, 0, 11);
        addVec(0, 0, 2'b00, 0, 0, 0, 1, word, 0, 32'h0000_80FF, 1, 1, 12);
        addVec(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_80FF, 0, 1, 12);

        mPending = 0; mRwd = 0; mType = 0; mAddr = 0; mCount = 0; expData = 0;
        expRwd = 0; expErr = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset");
        checkValue("reset_count_const", retire_count, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].rwdIn, vecs[i].sel, vecs[i].alu, vecs[i].link,
                          vecs[i].lt, vecs[i].rvalid, vecs[i].rdata, 0);
            checkOutput($sformatf("vec%0d_model", i));
            checkValue($sformatf("vec%0d_rwd", i), 32'(rwd), 32'(vecs[i].expRwd));
            checkValue($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].expData);
            checkValue($sformatf("vec%0d_align_err", i), 32'(align_err), 32'(vecs[i].expErr));
            checkValue($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            checkValue($sformatf("vec%0d_count", i), retire_count, 32'(vecs[i].expCount));
        end

        // Reset while a load is outstanding: the late read data must be ignored.
        applyStimulus(1, 4, 2'b01, 32'h2000, 0, 3'd0, 0, 0, 0);
        checkValue("rstld_wait_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("rstld_reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
        checkOutput("rstld_after");
        checkValue("rstld_rwd", 32'(rwd), 32'd0);
        checkValue("rstld_ready", 32'(in_ready), 32'd1);
        checkValue("rstld_busy", 32'(busy), 32'd0);
        checkValue("rstld_count", retire_count, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0]  a;
            logic [31:0] alu;
            a   = 2'($urandom_range(0, 3));
            alu = {$urandom} & 32'hFFFF_FFFC | 32'(a);
            applyStimulus($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)), alu, $urandom,
                          3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 99) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
